// File: rtl/phy_free_list.sv
// Circular free list of physical register tags for a 4-wide rename stage.
// Hands out up to four tags per cycle, takes back committed frees, and rolls back on flush.
module phy_free_list #(
  parameter int PHY_NUM  = 64,
  parameter int ARCH_NUM = 32,
  parameter int PW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          Stall,
  input  logic          Inst1_Req,
  input  logic          Inst2_Req,
  input  logic          Inst3_Req,
  input  logic          Inst4_Req,
  output logic [PW-1:0] Inst1_Phydst,
  output logic [PW-1:0] Inst2_Phydst,
  output logic [PW-1:0] Inst3_Phydst,
  output logic [PW-1:0] Inst4_Phydst,
  output logic          Alloc_Stall,
  input  logic [2:0]    Retire_Cnt,
  input  logic          Free1_Valid,
  input  logic          Free2_Valid,
  input  logic          Free3_Valid,
  input  logic          Free4_Valid,
  input  logic [PW-1:0] Free1_Phy,
  input  logic [PW-1:0] Free2_Phy,
  input  logic [PW-1:0] Free3_Phy,
  input  logic [PW-1:0] Free4_Phy,
  output logic [PW:0]   Free_Count
);
  localparam int PREL = PHY_NUM - ARCH_NUM;

  function automatic logic [PW:0] ext3(input logic [2:0] v);
    return {{(PW-2){1'b0}}, v};
  endfunction

  logic [PW-1:0] ram [PHY_NUM];
  logic [PW:0]   head, tail, head_cmt, inflight;
  logic [3:0]    req, fv;
  logic [PW-1:0] fphy [4];
  logic [PW-1:0] tag  [4];
  logic [PW:0]   widx [4];
  logic [2:0]    need, nfree;

  assign req     = {Inst4_Req, Inst3_Req, Inst2_Req, Inst1_Req};
  assign fphy[0] = Free1_Phy;
  assign fphy[1] = Free2_Phy;
  assign fphy[2] = Free3_Phy;
  assign fphy[3] = Free4_Phy;
  // A zero tag is never stored, so it does not take a tail slot
  assign fv = {Free4_Valid && (Free4_Phy != '0), Free3_Valid && (Free3_Phy != '0),
               Free2_Valid && (Free2_Phy != '0), Free1_Valid && (Free1_Phy != '0)};

  always_comb begin
    logic [PW:0] rptr;
    rptr = '0;
    need = '0;
    for (int n = 0; n < 4; n++) begin
      rptr   = head + ext3(need);
      tag[n] = req[n] ? ram[rptr[PW-1:0]] : '0;
      need   = need + {2'b00, req[n]};
    end
  end

  always_comb begin
    nfree = '0;
    for (int n = 0; n < 4; n++) begin
      widx[n] = tail + ext3(nfree);
      nfree   = nfree + {2'b00, fv[n]};
    end
  end

  assign Inst1_Phydst = tag[0];
  assign Inst2_Phydst = tag[1];
  assign Inst3_Phydst = tag[2];
  assign Inst4_Phydst = tag[3];
  assign Free_Count   = tail - head;
  assign Alloc_Stall  = ext3(need) > Free_Count;
  assign inflight     = head - head_cmt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      head_cmt <= '0;
      tail     <= (PW+1)'(PREL);
    end else begin
      head_cmt <= head_cmt + ext3(Retire_Cnt);
      // Flush rewinds to the committed head, including this cycle's retirements
      if (flush)
        head <= head_cmt + ext3(Retire_Cnt);
      else if (!Stall && !Alloc_Stall)
        head <= head + ext3(need);
      tail <= tail + ext3(nfree);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHY_NUM; i++)
        ram[i] <= (i < PREL) ? PW'(ARCH_NUM + i) : '0;
    end else begin
      for (int n = 0; n < 4; n++)
        if (fv[n]) ram[widx[n][PW-1:0]] <= fphy[n];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      assert (int'(Free_Count) + int'(nfree) <= PHY_NUM - 1);
      assert (int'(Retire_Cnt) <= int'(inflight));
    end
  end
endmodule

// File: tb/tb_phy_free_list.sv
// Bench for phy_free_list: directed steps followed by random traffic against a queue model.
module tb_phy_free_list;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst, flush, stall;
  logic [3:0]    req, fval;
  logic [2:0]    retire;
  logic [PW-1:0] fphy [4];
  logic [PW-1:0] ph [4];
  logic          astall;
  logic [PW:0]   fcnt;

  int fl[$];
  int hist[$];
  int seen[4];
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phy_free_list dut (
    .clk(clk), .rst(rst), .flush(flush), .Stall(stall),
    .Inst1_Req(req[0]), .Inst2_Req(req[1]), .Inst3_Req(req[2]), .Inst4_Req(req[3]),
    .Inst1_Phydst(ph[0]), .Inst2_Phydst(ph[1]), .Inst3_Phydst(ph[2]), .Inst4_Phydst(ph[3]),
    .Alloc_Stall(astall), .Retire_Cnt(retire),
    .Free1_Valid(fval[0]), .Free2_Valid(fval[1]), .Free3_Valid(fval[2]), .Free4_Valid(fval[3]),
    .Free1_Phy(fphy[0]), .Free2_Phy(fphy[1]), .Free3_Phy(fphy[2]), .Free4_Phy(fphy[3]),
    .Free_Count(fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    hist.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
  endtask

  // One clock: drive, check combinational outputs against the model, then advance the model
  task automatic step(input logic [3:0] r, input logic st, input logic fls, input int ret,
                      input logic [3:0] fv, input int p0, input int p1, input int p2, input int p3);
    int   need, k;
    logic exp_stall;
    int   pv[4];
    pv = '{p0, p1, p2, p3};
    @(negedge clk);
    req = r; stall = st; flush = fls; retire = 3'(ret); fval = fv;
    for (int n = 0; n < 4; n++) fphy[n] = PW'(pv[n]);
    #1;
    need = $countones(r);
    exp_stall = need > fl.size();
    chk("free_count", 32'(fcnt), fl.size());
    chk("alloc_stall", 32'(astall), 32'(exp_stall));
    k = 0;
    for (int n = 0; n < 4; n++) begin
      seen[n] = int'(ph[n]);
      if (!r[n]) chk($sformatf("tag%0d_idle", n + 1), 32'(ph[n]), 0);
      else begin
        if (!exp_stall) chk($sformatf("tag%0d", n + 1), 32'(ph[n]), fl[k]);
        k++;
      end
    end
    @(posedge clk);
    if (fls) begin
      repeat (ret) void'(hist.pop_front());
      fl = {hist, fl};
      hist.delete();
    end else begin
      if (!st && !exp_stall)
        for (int i = 0; i < need; i++) hist.push_back(fl.pop_front());
      repeat (ret) void'(hist.pop_front());
    end
    for (int n = 0; n < 4; n++)
      if (fv[n] && pv[n] != 0) fl.push_back(pv[n]);
  endtask

  initial begin
    rst = 1'b0; req = '0; stall = 1'b0; flush = 1'b0; retire = '0; fval = '0;
    for (int n = 0; n < 4; n++) fphy[n] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_count", 32'(fcnt), 32);
    chk("reset_stall", 32'(astall), 0);
    for (int n = 0; n < 4; n++) chk("reset_tag", 32'(ph[n]), 0);
    @(negedge clk);
    rst = 1'b1;

    // Four-wide allocation straight out of reset
    step(4'b1111, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    for (int n = 0; n < 4; n++) chk("first_tags", seen[n], 32 + n);
    #1 chk("count_after_4", 32'(fcnt), 28);

    // Compacted sparse request
    step(4'b1010, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    chk("sparse_slot1", seen[1], 36);
    chk("sparse_slot3", seen[3], 37);
    chk("sparse_slot0", seen[0], 0);
    chk("sparse_slot2", seen[2], 0);

    // Drain to two, then over-request and hold with Stall
    repeat (6) step(4'b1111, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    #1 chk("drained_count", 32'(fcnt), 2);
    step(4'b0111, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0011, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0);

    // Asynchronous reset mid-operation, then allocate 8 and flush with retire and a free
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_count", 32'(fcnt), 32);
    chk("midreset_stall", 32'(astall), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(4'b1111, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b1111, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0000, 0, 1, 2, 4'b0001, 5, 0, 0, 0);
    #1 chk("flush_count", 32'(fcnt), 31);

    // Zero tag in the middle of a free burst is dropped
    step(4'b0000, 0, 0, 0, 4'b0111, 5, 0, 7, 0);
    #1 chk("free_skip_zero", 32'(fcnt), 33);

    // Random traffic through many wraps
    for (int it = 0; it < 600; it++) begin
      logic [3:0] r, fv;
      logic       st, fls;
      int         ret, room, cnt, hs;
      int         p[4];
      r   = 4'($urandom);
      st  = ($urandom_range(0, 7) == 0);
      fls = ($urandom_range(0, 24) == 0);
      hs  = (hist.size() < 4) ? hist.size() : 4;
      ret = ($urandom_range(0, 3) == 0) ? $urandom_range(0, hs) : hs;
      room = 63 - fl.size() - hist.size();
      cnt = 0;
      for (int n = 0; n < 4; n++) begin
        fv[n] = 1'($urandom);
        p[n]  = $urandom_range(0, 63);
        if (fv[n] && p[n] != 0) begin
          if (cnt < room) cnt++;
          else fv[n] = 1'b0;
        end
      end
      step(r, st, fls, ret, fv, p[0], p[1], p[2], p[3]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
